// File: rtl/cache_pkg.sv
// Shared cache types: way count, way index/bit-vector types and the
// state encoding of the way-bit clear sequencer.
package cache_pkg;

    localparam int NUM_WAYS = 4;

    typedef logic [1:0]          way_t;
    typedef logic [NUM_WAYS-1:0] way_bits_t;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } way_clr_state_t;

endpackage

// File: rtl/way_bit_decode.sv
// 2-to-4 one-hot way decoder with enable; produces the per-way write
// strobe and is the inverse of the downstream bit-select mux.
module way_bit_decode
    import cache_pkg::*;
(
    input  logic       en,
    input  logic [1:0] way,
    output logic [3:0] strobe
);

    always_comb begin
        strobe = '0;
        if (en) begin
            strobe[way] = 1'b1;
        end
    end

endmodule

// File: rtl/way_bit_array.sv
// Per-set, per-way single-bit metadata store with a clear-all sequencer.
// Define WAY_BIT_BYPASS_EN to forward same-cycle writes/clears to rd_bits.
module way_bit_array
    import cache_pkg::*;
#(
    parameter int S_INDEX  = 4,
    parameter int NUM_SETS = 2**S_INDEX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S_INDEX-1:0] rd_set,
    output logic [3:0]         rd_bits,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_set,
    input  logic [1:0]         wr_way,
    input  logic               wr_bit,
    input  logic               clr_req,
    output logic               busy,
    output logic               clr_done
);

    // Completion is detected on the counter value itself, never on wrap.
    localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

    way_clr_state_t     state_q;
    way_clr_state_t     state_d;
    logic [S_INDEX-1:0] cnt_q;
    logic [S_INDEX-1:0] cnt_d;
    logic               clearing;
    logic               wr_active;
    way_bits_t          wr_strobe;
    way_bits_t          mem_q [NUM_SETS];
    way_bits_t          rd_next;

    assign wr_active = wr_en & ~busy;

    way_bit_decode u_decode (
        .en     (wr_active),
        .way    (wr_way),
        .strobe (wr_strobe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clearing = 1'b0;
        busy     = 1'b1;
        clr_done = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                busy = 1'b0;
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                clearing = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_SET) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                clr_done = 1'b1;
                state_d  = CLR_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = CLR_IDLE;
            end
        endcase
    end

    // Clear and write never coincide: writes are only accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                mem_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (clearing && (cnt_q == S_INDEX'(s))) begin
                    mem_q[s] <= '0;
                end else if (wr_set == S_INDEX'(s)) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (wr_strobe[w]) begin
                            mem_q[s][w] <= wr_bit;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_next = mem_q[rd_set];
`ifdef WAY_BIT_BYPASS_EN
        if (clearing && (cnt_q == rd_set)) begin
            rd_next = '0;
        end else if (wr_active && (wr_set == rd_set)) begin
            rd_next[wr_way] = wr_bit;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bits <= '0;
        end else begin
            rd_bits <= rd_next;
        end
    end

endmodule

// File: tb/tb_way_bit_array.sv
// Self-checking bench for way_bit_array: directed vector table, clear and
// reset-mid-clear sequences, and randomized traffic against a set/way model.
module tb_way_bit_array;

    logic       clk;
    logic       rst_n;
    logic [3:0] rd_set;
    logic [3:0] rd_bits;
    logic       wr_en;
    logic [3:0] wr_set;
    logic [1:0] wr_way;
    logic       wr_bit;
    logic       clr_req;
    logic       busy;
    logic       clr_done;

    int errors;
    int checks;

    // Reference: contents per set, plus cycles elapsed since a clear request
    // (-1 idle, 0..15 = next set to clear, 16 = completion cycle).
    logic [3:0] ref_mem [16];
    int         ref_phase;

    typedef struct {
        logic       we;
        int         ws;
        int         ww;
        logic       wb;
        int         rs;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [11];

    way_bit_array #(.S_INDEX(4), .NUM_SETS(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_set   (rd_set),
        .rd_bits  (rd_bits),
        .wr_en    (wr_en),
        .wr_set   (wr_set),
        .wr_way   (wr_way),
        .wr_bit   (wr_bit),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int s = 0; s < 16; s++) ref_mem[s] = 4'b0000;
        ref_phase = -1;
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, then compare.
    task automatic applyStimulus(input logic we, input int ws, input int ww,
                                 input logic wb, input int rs, input logic cr);
        logic [3:0] exp_rd;
        wr_en   = we;
        wr_set  = 4'(ws);
        wr_way  = 2'(ww);
        wr_bit  = wb;
        rd_set  = 4'(rs);
        clr_req = cr;

        exp_rd = ref_mem[rs];
`ifdef WAY_BIT_BYPASS_EN
        if (ref_phase >= 0 && ref_phase < 16 && ref_phase == rs) exp_rd = 4'b0000;
        else if (we && ref_phase == -1 && ws == rs) exp_rd[ww] = wb;
`endif
        if (ref_phase == -1) begin
            if (we) ref_mem[ws][ww] = wb;
            if (cr) ref_phase = 0;
        end else if (ref_phase < 16) begin
            ref_mem[ref_phase] = 4'b0000;
            ref_phase++;
        end else begin
            ref_phase = -1;
        end

        @(posedge clk);
        #1;
        checkOutput("rd_bits", rd_bits, exp_rd);
        checkOutput("busy", {3'b000, busy}, {3'b000, ref_phase >= 0});
        checkOutput("clr_done", {3'b000, clr_done}, {3'b000, ref_phase == 16});
    endtask

    initial begin
        int busy_cycles;
        int done_cnt;
        int done_at;

        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_set  = '0;
        wr_way  = '0;
        wr_bit  = 1'b0;
        rd_set  = '0;
        clr_req = 1'b0;
        resetModel();

        vecs[0]  = '{1'b0, 0, 0, 1'b0, 0,  4'b0000};
        vecs[1]  = '{1'b0, 0, 0, 1'b0, 15, 4'b0000};
        vecs[2]  = '{1'b1, 3, 2, 1'b1, 3,  4'b0000};
        vecs[3]  = '{1'b1, 3, 0, 1'b1, 3,  4'b0100};
        vecs[4]  = '{1'b0, 0, 0, 1'b0, 3,  4'b0101};
        vecs[5]  = '{1'b0, 0, 0, 1'b0, 2,  4'b0000};
        vecs[6]  = '{1'b0, 0, 0, 1'b0, 4,  4'b0000};
`ifdef WAY_BIT_BYPASS_EN
        vecs[7]  = '{1'b1, 7, 1, 1'b1, 7,  4'b0010};
`else
        vecs[7]  = '{1'b1, 7, 1, 1'b1, 7,  4'b0000};
`endif
        vecs[8]  = '{1'b0, 0, 0, 1'b0, 7,  4'b0010};
        vecs[9]  = '{1'b1, 3, 2, 1'b0, 0,  4'b0000};
        vecs[10] = '{1'b0, 0, 0, 1'b0, 3,  4'b0001};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rd_bits", rd_bits, 4'b0000);
        checkOutput("reset busy", {3'b000, busy}, 4'b0000);
        checkOutput("reset clr_done", {3'b000, clr_done}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].we, vecs[i].ws, vecs[i].ww, vecs[i].wb, vecs[i].rs, 1'b0);
            checkOutput($sformatf("vec%0d", i), rd_bits, vecs[i].exp);
        end

        $display("[TB] full clear with dropped write and repeated request");
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++)
                applyStimulus(1'b1, s, w, 1'b1, s, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1);
        busy_cycles = busy ? 1 : 0;
        done_cnt    = 0;
        done_at     = -1;
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(k == 10, 5, 1, 1'b1, k % 16, k == 5);
            if (busy) busy_cycles++;
            if (clr_done) begin
                done_cnt++;
                done_at = k;
            end
        end
        checkOutput("clear busy cycles", 4'(busy_cycles), 4'(17));
        checkOutput("clear done count", 4'(done_cnt), 4'(1));
        checkOutput("clear done edge", 4'(done_at), 4'(16));
        for (int s = 0; s < 16; s++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, s, 1'b0);
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 5, 1'b0);
        checkOutput("set5 after clear", rd_bits, 4'b0000);

        $display("[TB] reset in the middle of a clear");
        for (int s = 0; s < 16; s++) applyStimulus(1'b1, s, 3, 1'b1, s, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 15, 1'b1);
        for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 0, 0, 1'b0, 15, 1'b0);
        #1;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset busy", {3'b000, busy}, 4'b0000);
        checkOutput("midreset clr_done", {3'b000, clr_done}, 4'b0000);
        checkOutput("midreset rd_bits", rd_bits, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("held reset clr_done", {3'b000, clr_done}, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 20; s++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, s % 16, 1'b0);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
